jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
- Drives the J/K inputs of an external JK flip-flop so that Q follows a requested bit sequence. This is the inverse of exercising a JK flop, where J/K go in and Q comes out. Here the desired Q goes in and the block produces J/K.
- Targets are buffered in a small FIFO and converted with the JK excitation table against an internal Q model.
- The block checks the flop's fed-back Q one cycle after each drive and counts mismatches.
- Sits beside exe_4_msjk-style flops as a reusable stimulus source and self-checker.

Parameters:
- DEPTH, 4, target FIFO entries (power of 2, ≥2)
- DC_FILL, 0, value placed on excitation-table don't-care inputs (0 or 1)
- CW, 8, width of the error counter

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  synchronous, active-high; also resets the external flop, so the Q model starts at 0
- tgt_valid  in  1  target bit offered
- tgt_bit  in  1  desired next Q
- tgt_ready  out  1  FIFO can accept (= not full)
- q_fb  in  1  Q from the external flop
- J  out  1  registered J drive
- K  out  1  registered K drive
- drive_valid  out  1  J/K carry a target this cycle
- q_model  out  1  expected Q after the current or most recent drive
- err  out  1  one-cycle mismatch pulse
- err_count  out  CW  saturating mismatch count
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (reset=1 at a rising edge):
  - FIFO flushed; state goes to IDLE.
  - J=0, K=0, drive_valid=0, q_model=0, err=0, err_count=0.
  - tgt_ready=1 and busy=0 in the following cycle.
  - Reset overrides any in-flight drive or check with no residual pulses.
- Push: occurs on an edge where tgt_valid & tgt_ready. tgt_ready = (count != DEPTH). No push when full; tgt_valid is ignored then.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: if FIFO non-empty, pop the head target T and go to DRIVE. At the same edge, register J/K from (q_model, T), set drive_valid=1 and q_model<=T. Otherwise stay; J=K=0, drive_valid=0.
  - DRIVE (one cycle, J/K/drive_valid held): the external flop samples J/K at the next edge. Go to CHECK, with J=K=0 and drive_valid=0.
  - CHECK (one cycle): compare q_fb with q_model.
    - On mismatch: err=1 for the next cycle; err_count increments and saturates at 2^CW-1; q_model<=q_fb (resync so later excitations are correct).
    - Next state: if FIFO non-empty, pop and go straight to DRIVE (same action as IDLE). Else go to IDLE.
- Throughput and latency:
  - One target per 2 cycles when back-to-back.
  - A push at edge t gives drive_valid high in cycle t+1→t+2 at the earliest (FIFO empty and IDLE).
- Excitation table (q → T : J K, with d = DC_FILL):
  - 0→0 : 0 d
  - 0→1 : 1 d
  - 1→0 : d 1
  - 1→1 : d 0
  - So DC_FILL=0 gives hold/set/reset only. DC_FILL=1 gives 0→0=01, 0→1=11, 1→0=11, 1→1=10.
- Push and pop on the same edge: allowed when the FIFO is non-full and non-empty; count is unchanged.
- Pointers wrap modulo DEPTH.
- q_fb is ignored outside CHECK.
- busy=0 only in IDLE with the FIFO empty.

Test Plan:
- Reset, then push 1,0,1,1,0 back-to-back (DC_FILL=0) with a correct flop → J/K sequence 10,01,10,00,01; q_model 1,0,1,1,0; err never asserts; err_count=0.
- DC_FILL=1, push 0,1,0,0 from q=0 → J/K 01,11,11,01; q_model 0,1,0,0.
- Push DEPTH+2=6 bits with the FSM stalled at reset release → tgt_ready drops after 4 accepted; the 5th is held until the first pop; all 6 are driven in order.
- Force q_fb=0 during the CHECK after target 1 → err pulses 1 cycle; err_count=1; q_model resyncs to 0; the next target 1 drives J=1, K=0.
- Saturation with CW=2: inject 5 mismatches → err_count sticks at 3; err still pulses each time.
- Assert reset during DRIVE with 3 targets queued → next cycle J=K=0, drive_valid=0, busy=0, q_model=0, err_count=0; nothing further is driven.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Converts a stream of desired Q bits into registered J/K drives for an external
// JK flop, then checks the flop's fed-back Q one cycle after each drive.
module jk_excitation_driver #(
  parameter int DEPTH   = 4,
  parameter bit DC_FILL = 1'b0,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tgt_valid,
  input  logic          tgt_bit,
  output logic          tgt_ready,
  input  logic          q_fb,
  output logic          J,
  output logic          K,
  output logic          drive_valid,
  output logic          q_model,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic          busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t        state;
  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic head;
  logic q_cur;
  logic mismatch;
  logic j_next;
  logic k_next;

  assign tgt_ready = (count != (AW+1)'(DEPTH));
  assign push      = tgt_valid && tgt_ready;
  assign pop       = ((state == IDLE) || (state == CHECK)) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE);
  assign mismatch  = (state == CHECK) && (q_fb != q_model);

  // A pop straight out of CHECK must excite from the flop's real state, so the
  // fed-back Q stands in for the model there (it equals the model unless resyncing).
  assign q_cur  = (state == CHECK) ? q_fb : q_model;
  assign j_next = q_cur ? DC_FILL : head;
  assign k_next = q_cur ? ~head   : DC_FILL;

  // NOTE: FIFO storage carries no reset; the pointers and count define which
  // entries are valid, so flushing them is enough and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tgt_bit;
  end

  // NOTE: every register here uses <= so all of them see the same pre-edge
  // values; the later q_model assignment on a pop intentionally wins a resync.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      J           <= 1'b0;
      K           <= 1'b0;
      drive_valid <= 1'b0;
      q_model     <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      err <= mismatch;
      if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;

      J           <= 1'b0;
      K           <= 1'b0;
      drive_valid <= 1'b0;

      case (state)
        IDLE, CHECK: begin
          if (mismatch) q_model <= q_fb;
          if (pop) begin
            state       <= DRIVE;
            J           <= j_next;
            K           <= k_next;
            drive_valid <= 1'b1;
            q_model     <= head;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE:   state <= CHECK;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Two instances (DC_FILL=0/CW=8 and DC_FILL=1/CW=2) share one stimulus stream and
// are each paired with a behavioural JK flop; a transaction-level model predicts outputs.
module tb_jk_excitation_driver;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tgt_valid, tgt_bit;
  logic q_fb [2];
  logic j_o [2], k_o [2], dv [2], qm [2], err_o [2], rdy [2], busy_o [2];
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic q_ext [2];
  logic force_en, force_val;

  jk_excitation_driver #(.DEPTH(DEPTH), .DC_FILL(1'b0), .CW(8)) u_dut0 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(rdy[0]), .q_fb(q_fb[0]), .J(j_o[0]), .K(k_o[0]),
    .drive_valid(dv[0]), .q_model(qm[0]), .err(err_o[0]), .err_count(ec0),
    .busy(busy_o[0]));

  jk_excitation_driver #(.DEPTH(DEPTH), .DC_FILL(1'b1), .CW(2)) u_dut1 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(rdy[1]), .q_fb(q_fb[1]), .J(j_o[1]), .K(k_o[1]),
    .drive_valid(dv[1]), .q_model(qm[1]), .err(err_o[1]), .err_count(ec1),
    .busy(busy_o[1]));

  // External JK flops, reset together with the driver
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) q_ext[i] <= 1'b0;
      else       q_ext[i] <= (j_o[i] & ~q_ext[i]) | (~k_o[i] & q_ext[i]);
    end
  end

  assign q_fb[0] = force_en ? force_val : q_ext[0];
  assign q_fb[1] = force_en ? force_val : q_ext[1];

  typedef struct {
    bit       t;
    bit [1:0] jk0;
    bit [1:0] jk1;
  } vec_t;
  vec_t vecs [9];

  int total = 0;
  int bad   = 0;

  bit         tq [$];
  bit         q_ref [2];
  int         cnt_ref [2];
  bit         err_next [2];
  bit         q_saved [2];
  int         pulses [2];
  bit         resync_pend, prev_dv, t_cur, saw_full;
  int         prev_size, want_corrupt;
  logic [1:0] log_jk0 [$];
  logic [1:0] log_jk1 [$];
  logic       log_qm0 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exc(input bit q, input bit t, input bit d);
    case ({q, t})
      2'b00:   return {1'b0, d};
      2'b01:   return {1'b1, d};
      2'b10:   return {d, 1'b1};
      default: return {d, 1'b0};
    endcase
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic logic [31:0] ec_of(input int i);
    return (i == 0) ? 32'(ec0) : 32'(ec1);
  endfunction

  task automatic monitor(input bit r);
    bit exp_dv, chk_now, t;
    logic [1:0] ejk;
    t = 1'b0;
    if (r) begin
      prev_dv = 1'b0; prev_size = 0; resync_pend = 1'b0; force_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_ref[i] = 1'b0; cnt_ref[i] = 0; err_next[i] = 1'b0;
      end
    end
    chk_now = prev_dv;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("err%0d", i), err_o[i], err_next[i]);
      check($sformatf("err_count%0d", i), ec_of(i), cnt_ref[i]);
      if (err_o[i] === 1'b1) pulses[i]++;
      if (resync_pend) q_ref[i] = q_saved[i];
      err_next[i] = 1'b0;
      if (chk_now) begin
        q_saved[i] = q_fb[i];
        if (q_fb[i] !== t_cur) begin
          err_next[i] = 1'b1;
          if (cnt_ref[i] < cmax(i)) cnt_ref[i]++;
        end
      end
    end
    resync_pend = chk_now;
    if (!chk_now) force_en = 1'b0;
    // Targets issue one per two cycles: a non-empty FIFO drives unless the last cycle drove
    exp_dv = (prev_size != 0) && !prev_dv;
    if (exp_dv) begin
      t = tq.pop_front();
      t_cur = t;
      if (want_corrupt > 0) begin
        force_en = 1'b1; force_val = ~t; want_corrupt--;
      end
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("drive_valid%0d", i), dv[i], exp_dv);
      ejk = exp_dv ? exc(q_ref[i], t, (i == 1)) : 2'b00;
      check($sformatf("jk%0d", i), {j_o[i], k_o[i]}, ejk);
      if (exp_dv) q_ref[i] = t;
      check($sformatf("q_model%0d", i), qm[i], q_ref[i]);
      check($sformatf("tgt_ready%0d", i), rdy[i], tq.size() != DEPTH);
      check($sformatf("busy%0d", i), busy_o[i], (tq.size() != 0) || exp_dv || chk_now);
    end
    if (exp_dv) begin
      log_jk0.push_back({j_o[0], k_o[0]});
      log_jk1.push_back({j_o[1], k_o[1]});
      log_qm0.push_back(qm[0]);
    end
    prev_dv   = exp_dv;
    prev_size = tq.size();
    if (tq.size() == DEPTH) saw_full = 1'b1;
  endtask

  task automatic step(input bit v, input bit b, input bit r, output bit acc);
    tgt_valid = v; tgt_bit = b; reset = r;
    @(posedge clk);
    acc = !r && v && (tq.size() != DEPTH);
    if (r) tq.delete();
    else if (acc) tq.push_back(b);
    @(negedge clk);
    monitor(r);
  endtask

  task automatic idle();
    bit a;
    step(1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic do_reset();
    bit a;
    step(1'b0, 1'b0, 1'b1, a);
    log_jk0.delete(); log_jk1.delete(); log_qm0.delete();
    pulses[0] = 0; pulses[1] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((tq.size() != 0 || prev_dv) && n < 60) begin
      idle();
      n++;
    end
    check("drain_bound", n < 60, 1);
    idle();
    idle();
  endtask

  task automatic apply_segment(input int lo, input int hi);
    bit a;
    for (int k = lo; k <= hi; k++) step(1'b1, vecs[k].t, 1'b0, a);
    drain();
    check("seg_len0", log_jk0.size(), hi - lo + 1);
    check("seg_len1", log_jk1.size(), hi - lo + 1);
    for (int k = lo; k <= hi; k++) begin
      if (k - lo < log_jk0.size() && k - lo < log_jk1.size()) begin
        check($sformatf("seg_jk0_%0d", k), log_jk0[k-lo], vecs[k].jk0);
        check($sformatf("seg_jk1_%0d", k), log_jk1[k-lo], vecs[k].jk1);
        check($sformatf("seg_qm_%0d", k), log_qm0[k-lo], vecs[k].t);
      end
    end
    check("seg_errs0", pulses[0], 0);
    check("seg_errs1", pulses[1], 0);
  endtask

  initial begin
    bit a;
    int n;
    bit [9:0] pat;
    reset = 1'b1; tgt_valid = 1'b0; tgt_bit = 1'b0;
    force_en = 1'b0; force_val = 1'b0;
    want_corrupt = 0; saw_full = 1'b0; t_cur = 1'b0;
    prev_dv = 1'b0; prev_size = 0; resync_pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q_ref[i] = 1'b0; cnt_ref[i] = 0; err_next[i] = 1'b0; q_saved[i] = 1'b0; pulses[i] = 0;
    end

    // {target, expected JK for DC_FILL=0, expected JK for DC_FILL=1}, each run from reset
    vecs[0] = '{1'b1, 2'b10, 2'b11};
    vecs[1] = '{1'b0, 2'b01, 2'b11};
    vecs[2] = '{1'b1, 2'b10, 2'b11};
    vecs[3] = '{1'b1, 2'b00, 2'b10};
    vecs[4] = '{1'b0, 2'b01, 2'b11};
    vecs[5] = '{1'b0, 2'b00, 2'b01};
    vecs[6] = '{1'b1, 2'b10, 2'b11};
    vecs[7] = '{1'b0, 2'b01, 2'b11};
    vecs[8] = '{1'b0, 2'b00, 2'b01};

    @(negedge clk);
    do_reset();
    do_reset();
    check("rst_ready", rdy[0], 1);
    check("rst_busy", busy_o[0], 0);

    apply_segment(0, 4);
    do_reset();
    apply_segment(5, 8);

    // Over-subscribe the FIFO: pushes every cycle outrun the 1-per-2 drain
    do_reset();
    saw_full = 1'b0;
    pat = 10'b1011001110;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin
        step(1'b1, pat[k], 1'b0, a);
        n++;
      end while (!a && n < 20);
      check("push_bound", n < 20, 1);
    end
    drain();
    check("saw_full", saw_full, 1);
    check("fill_len", log_qm0.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < log_qm0.size()) check($sformatf("fill_order%0d", k), log_qm0[k], pat[k]);

    // Single forced mismatch, then another target 1 popped right out of CHECK
    do_reset();
    want_corrupt = 1;
    step(1'b1, 1'b1, 1'b0, a);
    idle();
    step(1'b1, 1'b1, 1'b0, a);
    drain();
    check("mm_count0", ec0, 1);
    check("mm_pulses0", pulses[0], 1);
    // DC_FILL=1 toggles the real flop back to 0 on the resynced drive: a second miss
    check("mm_count1", ec1, 2);
    if (log_jk0.size() >= 2) begin
      check("mm_jk0", log_jk0[1], 2'b10);
      check("mm_jk1", log_jk1[1], 2'b11);
    end

    // Saturation of the 2-bit counter
    do_reset();
    want_corrupt = 5;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, a);
    drain();
    check("sat_count0", ec0, 5);
    check("sat_count1", ec1, 3);
    check("sat_pulses0", pulses[0], 5);
    check("sat_pulses1", pulses[1], 5);

    // Reset while a drive is in flight with targets still queued
    do_reset();
    n = 0;
    do begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, a);
      n++;
    end while (!(prev_dv && tq.size() >= 3) && n < 20);
    check("rst_setup_bound", n < 20, 1);
    do_reset();
    check("rst_dv", dv[0], 0);
    check("rst_jk", {j_o[0], k_o[0]}, 0);
    check("rst_busy0", busy_o[0], 0);
    check("rst_qm", qm[0], 0);
    check("rst_ec", ec0, 0);
    repeat (6) idle();
    check("rst_no_drive", log_jk0.size(), 0);

    // Randomized traffic with occasional mismatches and resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0 && want_corrupt == 0) want_corrupt = 1;
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 199) == 0, a);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
